// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: frames one command per request with SS_n and sends {cmd,payload} MSB-first.
// Read-data frames wait out the slave turnaround, then collect 8 MISO bits into rd_data.
module spi_master_ctrl #(
   parameter int RD_WAIT = 2,
   parameter int GAP     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [7:0] payload,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       MOSI,
   output logic       SS_n,
   input  logic       MISO
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHK,
      S_SHIFT,
      S_WAIT,
      S_READ,
      S_GAP
   } state_t;

   localparam logic [3:0] WaitLoad = 4'(RD_WAIT - 1);
   localparam logic [3:0] GapLoad  = 4'(GAP - 1);

   state_t     state_q, state_d;
   logic [9:0] frame_q, frame_d;
   logic       isRead_q, isRead_d;
   logic [3:0] bitCnt_q, bitCnt_d;
   logic [3:0] waitCnt_q, waitCnt_d;
   logic [7:0] capture_q, capture_d;
   logic [7:0] rdData_q, rdData_d;
   logic       ssN, mosi, doneC;

   // State and datapath registers; reset drops SS_n and MOSI at once because both decode from state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         frame_q   <= 10'd0;
         isRead_q  <= 1'b0;
         bitCnt_q  <= 4'd0;
         waitCnt_q <= 4'd0;
         capture_q <= 8'h00;
         rdData_q  <= 8'h00;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         isRead_q  <= isRead_d;
         bitCnt_q  <= bitCnt_d;
         waitCnt_q <= waitCnt_d;
         capture_q <= capture_d;
         rdData_q  <= rdData_d;
      end
   end

   // Next-state and pin decode; counters are reloaded on the transition into the state that uses them.
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      isRead_d  = isRead_q;
      bitCnt_d  = bitCnt_q;
      waitCnt_d = waitCnt_q;
      capture_d = capture_q;
      rdData_d  = rdData_q;
      ssN       = 1'b1;
      mosi      = 1'b0;
      doneC     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               frame_d  = {cmd, payload};
               isRead_d = (cmd == 2'b11);
               state_d  = S_CHK;
            end
         end
         S_CHK: begin
            ssN      = 1'b0;
            mosi     = frame_q[9];
            bitCnt_d = 4'd9;
            state_d  = S_SHIFT;
         end
         S_SHIFT: begin
            ssN  = 1'b0;
            mosi = frame_q[bitCnt_q];
            if (bitCnt_q == 4'd0) begin
               if (isRead_q) begin
                  waitCnt_d = WaitLoad;
                  state_d   = S_WAIT;
               end else begin
                  waitCnt_d = GapLoad;
                  state_d   = S_GAP;
               end
            end else begin
               bitCnt_d = bitCnt_q - 4'd1;
            end
         end
         S_WAIT: begin
            ssN = 1'b0;
            if (waitCnt_q == 4'd0) begin
               bitCnt_d = 4'd7;
               state_d  = S_READ;
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         S_READ: begin
            ssN       = 1'b0;
            capture_d = {capture_q[6:0], MISO};
            if (bitCnt_q == 4'd0) begin
               waitCnt_d = GapLoad;
               state_d   = S_GAP;
            end else begin
               bitCnt_d = bitCnt_q - 4'd1;
            end
         end
         S_GAP: begin
            if (waitCnt_q == 4'd0) begin
               doneC   = 1'b1;
               state_d = S_IDLE;
               if (isRead_q) begin
                  rdData_d = capture_q;
               end
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = doneC;
   assign rd_valid = doneC & isRead_q;
   assign MOSI     = mosi;
   assign SS_n     = ssN;
   // The fresh byte is visible in the done cycle itself; the register holds it afterwards.
   assign rd_data  = rd_valid ? capture_q : rdData_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomised and directed bench for spi_master_ctrl with a frame-level reference model.
// A second instance exercises RD_WAIT=3, GAP=2 against a behavioural slave.
module tb_spi_master_ctrl;

   localparam int RdWait  = 2;
   localparam int Gap     = 1;
   localparam int RdWait2 = 3;
   localparam int Gap2    = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, start2 = 1'b0;
   logic [1:0] cmd = 2'b00, cmd2 = 2'b00;
   logic [7:0] payload = 8'h00, payload2 = 8'h00;
   logic       MISO = 1'b0, MISO2 = 1'b0;
   logic       busy, done, rd_valid, MOSI, SS_n;
   logic       busy2, done2, rd_valid2, MOSI2, SS_n2;
   logic [7:0] rd_data, rd_data2;

   int checks = 0;
   int errors = 0;

   spi_master_ctrl #(.RD_WAIT(RdWait), .GAP(Gap)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .payload(payload),
      .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
      .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO)
   );

   spi_master_ctrl #(.RD_WAIT(RdWait2), .GAP(Gap2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .cmd(cmd2), .payload(payload2),
      .busy(busy2), .done(done2), .rd_data(rd_data2), .rd_valid(rd_valid2),
      .MOSI(MOSI2), .SS_n(SS_n2), .MISO(MISO2)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural slaves: return slaveByte MSB-first in the read window, or random bits.
   logic [7:0] slaveByte = 8'h00, slaveByte2 = 8'h00;
   bit         randomMiso = 1'b0;
   int         run1 = 0, run2 = 0, p1, p2;

   always @(posedge clk) begin
      #1;
      MISO  = 1'b0;
      MISO2 = 1'b0;
      if (SS_n) run1 = 0;
      else begin
         p1 = run1;
         run1++;
         if (randomMiso) MISO = 1'($urandom);
         else if (p1 >= 11 + RdWait && p1 < 19 + RdWait) MISO = slaveByte[7 - (p1 - 11 - RdWait)];
      end
      if (SS_n2) run2 = 0;
      else begin
         p2 = run2;
         run2++;
         if (p2 >= 11 + RdWait2 && p2 < 19 + RdWait2) MISO2 = slaveByte2[7 - (p2 - 11 - RdWait2)];
      end
   end

   // Reference model: a frame is a position counter over SS_n-low cycles followed by Gap cycles.
   int         pos = -1;
   int         lowLen = 11;
   logic [9:0] mFrame = 10'd0;
   logic [10:0] seq;
   bit         mRd = 1'b0;
   logic [7:0] mCap = 8'h00, expRd = 8'h00;
   logic       expSs, expMosi, expBusy, expDone, expValid;

   always @(negedge clk) begin
      if (!rst_n) begin
         pos   = -1;
         expRd = 8'h00;
         mCap  = 8'h00;
         checkOutput("rstSS_n", SS_n, 1);
         checkOutput("rstMOSI", MOSI, 0);
         checkOutput("rstBusy", busy, 0);
         checkOutput("rstDone", done, 0);
         checkOutput("rstValid", rd_valid, 0);
         checkOutput("rstRdData", rd_data, 0);
      end else begin
         seq      = {mFrame[9], mFrame};
         expBusy  = (pos >= 0);
         expSs    = !(pos >= 0 && pos < lowLen);
         expMosi  = (pos >= 0 && pos <= 10) ? seq[10 - pos] : 1'b0;
         if (mRd && pos >= 11 + RdWait && pos < 19 + RdWait) mCap = {mCap[6:0], MISO};
         expDone  = (pos == lowLen + Gap - 1);
         expValid = expDone && mRd;
         if (expValid) expRd = mCap;
         checkOutput("SS_n", SS_n, expSs);
         checkOutput("MOSI", MOSI, expMosi);
         checkOutput("busy", busy, expBusy);
         checkOutput("done", done, expDone);
         checkOutput("rd_valid", rd_valid, expValid);
         checkOutput("rd_data", rd_data, expRd);
         if (pos >= 0) begin
            pos++;
            if (pos == lowLen + Gap) pos = -1;
         end else if (start) begin
            pos    = 0;
            mFrame = {cmd, payload};
            mRd    = (cmd == 2'b11);
            lowLen = mRd ? 19 + RdWait : 11;
            mCap   = 8'h00;
         end
      end
   end

   // Frame monitors feeding the literal checks.
   int   curLow = 0, curHigh = 0, lastLen = 0, lastHigh = 0, doneCnt = 0, validCnt = 0, frameCnt = 0;
   int   curLow2 = 0, curHigh2 = 0, lastLen2 = 0, lastHigh2 = 0, doneCnt2 = 0;
   logic [31:0] bits = 0, lastBits = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         curLow  = 0; curHigh  = 0; bits = 0;
         curLow2 = 0; curHigh2 = 0;
      end else begin
         if (!SS_n) begin
            if (curLow == 0) begin
               lastHigh = curHigh;
               frameCnt++;
               bits = 0;
            end
            curLow++;
            curHigh = 0;
            bits = {bits[30:0], MOSI};
         end else begin
            if (curLow != 0) begin
               lastLen  = curLow;
               lastBits = bits;
            end
            curLow = 0;
            curHigh++;
         end
         if (done) doneCnt++;
         if (rd_valid) validCnt++;
         if (!SS_n2) begin
            if (curLow2 == 0) lastHigh2 = curHigh2;
            curLow2++;
            curHigh2 = 0;
         end else begin
            if (curLow2 != 0) lastLen2 = curLow2;
            curLow2 = 0;
            curHigh2++;
         end
         if (done2) doneCnt2++;
      end
   end

   task automatic waitDone(input int inst, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = (inst == 1) ? done : done2;
      end
      if (!seen) checkOutput({name, "Timeout"}, 0, 1);
   endtask

   task automatic applyStimulus(input int inst, input logic [1:0] c, input logic [7:0] p);
      @(posedge clk); #2;
      if (inst == 1) begin start = 1'b1; cmd = c; payload = p; end
      else begin start2 = 1'b1; cmd2 = c; payload2 = p; end
      @(posedge clk); #2;
      if (inst == 1) begin start = 1'b0; cmd = 2'($urandom); payload = 8'($urandom); end
      else begin start2 = 1'b0; cmd2 = 2'($urandom); payload2 = 8'($urandom); end
      waitDone(inst, "frame");
      @(posedge clk); #3;
   endtask

   int d0, v0, f0;

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetSS_n", SS_n, 1);
      checkOutput("resetMOSI", MOSI, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetRdData", rd_data, 8'h00);
      @(posedge clk); #2;
      rst_n = 1'b1;

      // Write address FF
      d0 = doneCnt; v0 = validCnt;
      applyStimulus(1, 2'b00, 8'hFF);
      checkOutput("wrAddrLen", lastLen, 11);
      checkOutput("wrAddrBits", lastBits[10:0], 11'b00011111111);
      checkOutput("wrAddrDone", doneCnt - d0, 1);
      checkOutput("wrAddrValid", validCnt - v0, 0);

      // Write data AA
      applyStimulus(1, 2'b01, 8'hAA);
      checkOutput("wrDataLen", lastLen, 11);
      checkOutput("wrDataBits", lastBits[10:0], 11'b00110101010);

      // Read address 03
      applyStimulus(1, 2'b10, 8'h03);
      checkOutput("rdAddrBits", lastBits[10:0], 11'b11000000011);

      // Read data with slave returning B2
      slaveByte = 8'hB2;
      v0 = validCnt;
      applyStimulus(1, 2'b11, 8'h00);
      checkOutput("rdDataLen", lastLen, 21);
      checkOutput("rdDataBits", lastBits[20:0], {11'b11100000000, 10'b0});
      checkOutput("rdDataByte", rd_data, 8'hB2);
      checkOutput("rdDataValid", validCnt - v0, 1);

      // Starts during busy are dropped
      f0 = frameCnt;
      @(posedge clk); #2; start = 1'b1; cmd = 2'b00; payload = 8'h55;
      @(posedge clk); #2; start = 1'b0;
      @(posedge clk); #2; start = 1'b1;
      @(posedge clk); #2; start = 1'b0;
      repeat (3) @(posedge clk);
      #2; start = 1'b1;
      @(posedge clk); #2; start = 1'b0;
      waitDone(1, "ignored");
      repeat (6) @(posedge clk);
      #3;
      checkOutput("ignoredStarts", frameCnt - f0, 1);
      checkOutput("rdDataHeld", rd_data, 8'hB2);

      // Back-to-back: start held from the done cycle
      @(posedge clk); #2; start = 1'b1; cmd = 2'b01; payload = 8'h3C;
      @(posedge clk); #2; start = 1'b0;
      waitDone(1, "b2bFirst");
      #1; start = 1'b1; cmd = 2'b00; payload = 8'h81;
      @(posedge clk);
      @(posedge clk); #2; start = 1'b0;
      waitDone(1, "b2bSecond");
      @(posedge clk); #3;
      checkOutput("b2bHigh", lastHigh, 2);
      checkOutput("b2bBits", lastBits[10:0], 11'b00010000001);

      // Reset in the middle of SHIFT
      d0 = doneCnt;
      @(posedge clk); #2; start = 1'b1; cmd = 2'b10; payload = 8'hF0;
      @(posedge clk); #2; start = 1'b0;
      repeat (3) @(posedge clk);
      #2; rst_n = 1'b0;
      #1;
      checkOutput("midRstSS_n", SS_n, 1);
      checkOutput("midRstMOSI", MOSI, 0);
      checkOutput("midRstRdData", rd_data, 8'h00);
      @(posedge clk);
      @(posedge clk); #2; rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #3;
      checkOutput("midRstNoDone", doneCnt - d0, 0);
      checkOutput("midRstIdle", SS_n, 1);

      // Random traffic, random MISO
      randomMiso = 1'b1;
      repeat (800) begin
         @(posedge clk); #2;
         start   = ($urandom_range(0, 2) == 0);
         cmd     = 2'($urandom);
         payload = 8'($urandom);
      end
      start = 1'b0;
      repeat (40) @(posedge clk);
      randomMiso = 1'b0;

      // Parameter sweep instance: RD_WAIT=3, GAP=2, slave returns 5C
      slaveByte2 = 8'h5C;
      applyStimulus(2, 2'b11, 8'h00);
      checkOutput("sweepLen", lastLen2, 22);
      checkOutput("sweepByte", rd_data2, 8'h5C);
      applyStimulus(2, 2'b01, 8'h12);
      checkOutput("sweepWrLen", lastLen2, 11);
      checkOutput("sweepHeld", rd_data2, 8'h5C);
      d0 = doneCnt2;
      @(posedge clk); #2; start2 = 1'b1; cmd2 = 2'b00; payload2 = 8'h07;
      @(posedge clk); #2; start2 = 1'b0;
      waitDone(2, "sweepB2bFirst");
      #1; start2 = 1'b1; cmd2 = 2'b11; payload2 = 8'h00; slaveByte2 = 8'hA6;
      @(posedge clk);
      @(posedge clk); #2; start2 = 1'b0;
      waitDone(2, "sweepB2bSecond");
      @(posedge clk); #3;
      checkOutput("sweepHigh", lastHigh2, 3);
      checkOutput("sweepB2bLen", lastLen2, 22);
      checkOutput("sweepB2bByte", rd_data2, 8'hA6);
      checkOutput("sweepDoneCnt", doneCnt2 - d0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Host-side SPI master that drives the MOSI/SS_n/MISO interface of the existing SPI-slave + single-port RAM top.
- Accepts one command per request: write address, write data, read address or read data.
- Frames each transaction with SS_n and serialises the command and payload MSB-first.
- On a read-data command, waits for the slave turnaround, then captures the 8 returned bits and presents them as a parallel byte.

Parameters:
- RD_WAIT, 2, cycles between the last payload bit and the first MISO sample on a read-data (cmd 11) frame; legal range 1..15.
- GAP, 1, minimum cycles SS_n is held high between frames; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge; SPI runs at clk rate.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only while busy=0.
- cmd  input  2  00 write address, 01 write data, 10 read address, 11 read data.
- payload  input  8  address, write data or dummy byte (ignored for cmd 11).
- busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
- done  output  1  one-cycle pulse at end of transaction, after the GAP has elapsed.
- rd_data  output  8  byte captured from MISO; updated only on cmd 11.
- rd_valid  output  1  one-cycle pulse coincident with done on cmd 11 only.
- MOSI  output  1  serial data to slave, changes on rising clk.
- SS_n  output  1  slave select, active-low.
- MISO  input  1  serial data from slave, sampled on rising clk.

Behaviour:
- Reset values: SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, state=IDLE, all counters=0.
- Reset asserted mid-frame: SS_n returns to 1 and MOSI to 0 immediately (asynchronous). No done pulse. rd_data is cleared.
- Accept: in IDLE, start=1 latches frame={cmd,payload} (10 bits) and the command. From the next cycle busy=1. start is ignored while busy=1 (no queueing).
- States: IDLE -> CHK -> SHIFT -> (WAIT -> READ, cmd 11 only) -> GAP -> IDLE.
- CHK: 1 cycle. SS_n=0, MOSI=frame[9]. This is the slave's command-select bit.
- SHIFT: 10 cycles. MOSI=frame[9], frame[8], ..., frame[0]. SS_n=0.
  - cmd 00/01/10 -> GAP after the 10th bit.
  - cmd 11 -> WAIT.
- WAIT: RD_WAIT cycles, SS_n=0, MOSI=0.
- READ: 8 cycles, SS_n=0, MOSI=0. MISO is shifted into a capture register MSB-first (first sample becomes bit 7).
- GAP: SS_n=1, MOSI=0 for GAP cycles. On the last GAP cycle, done=1 and busy drops on the following edge.
  - For cmd 11, rd_data is loaded from the capture register in that same cycle and rd_valid=1.
- SS_n low duration:
  - Write and read-address frames: exactly 11 cycles.
  - Read-data frame: 11+RD_WAIT+8 cycles (21 at default).
- Back-to-back: start may be asserted in the cycle done is high. It is accepted only once state=IDLE (next cycle), so SS_n-high ≥ GAP+1 cycles between frames.
- Counters: bit counter 4 bits, wait counter 4 bits. Neither wraps; each reload occurs on state entry.
- cmd/payload changing after acceptance has no effect on the current frame.
- rd_data holds its value until the next cmd 11 completes or reset.

Test Plan:
- Reset check: rst_n=0 for 2 cycles -> SS_n=1, MOSI=0, busy=0, rd_data=00. Release, then assert rst_n=0 mid-SHIFT -> SS_n=1 in the same cycle, no done pulse.
- Write address: start with cmd=00, payload=FF -> SS_n low exactly 11 cycles; MOSI sequence 0,0,0,1,1,1,1,1,1,1,1; single done pulse; rd_valid stays 0.
- Write data: cmd=01, payload=AA -> MOSI 0,0,1,1,0,1,0,1,0,1,0. Against the RAM top, preceded by write-address FF, mem[255]=AA afterwards.
- Read round-trip:
  - cmd=10, payload=03 -> MOSI 1,1,0,0,0,0,0,0,0,1,1.
  - Then cmd=11 with mem[3] preloaded B2 -> SS_n low 21 cycles; rd_data=B2 and rd_valid=1 with done.
- Ignored start and back-to-back: pulse start twice during busy -> exactly one frame. Assert start on the done cycle -> the next frame's SS_n falls after ≥2 high cycles.
- Parameter sweep: RD_WAIT=3, GAP=2 with a behavioural slave model returning 5C -> SS_n low 22 cycles, high ≥3 between frames, rd_data=5C.
